uart_rx_byte: RTL and testbench

Byte-level UART receiver that turns the raw asynchronous PC serial line into single-cycle byte strobes for the 32-bit word serialiser. It is the stage directly upstream of the serialiser. It oversamples the line with a counter derived from the system clock and frames 8N1 characters; optional even parity is selected at build time. Each good byte produces a one-cycle data-valid pulse.

---
 rtl/uart_rx_byte_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_byte.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared UART receive definitions: FSM state encoding, default bit period, frame length.
// The frame length follows the UART_RX_PARITY_EN build option.
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

`ifdef UART_RX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability flop chain for an asynchronous line that idles high.
// Every stage resets to 1 so a reset never looks like a start bit.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with single-cycle byte strobes and error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with the o_rx_parity_err output.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_byte_data,
    output logic       o_rx_byte_recv_sig,
    output logic       o_rx_frame_err,
    output logic       o_rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_rx_parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    rx_state_e        state_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [7:0]       data_q;
    logic             recv_q;
    logic             ferr_q;
    logic             busy_q;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             perr_q;
`endif

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_d       (i_uart_rx),
        .o_q       (rx_s)
    );

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_W'(1);
    assign shift_d  = {rx_s, shift_q[7:1]};

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            cnt_q     <= BIT_M1;
            bit_q     <= 3'd0;
            data_q    <= 8'h00;
            recv_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            recv_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (armed_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= HALF_M1;
                        busy_q  <= 1'b1;
                    end else if (!armed_q) begin
                        // Arm only after a full bit period of continuous idle-high line
                        if (!rx_s) begin
                            cnt_q <= BIT_M1;
                        end else if (cnt_zero) begin
                            armed_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_dec;
                        end
                    end
                end
                START: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_dec;
                    end else if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA;
                        cnt_q   <= BIT_M1;
                        bit_q   <= 3'd0;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_dec;
                    end else begin
                        shift_q <= shift_d;
                        bit_q   <= bit_q + 3'd1;
                        cnt_q   <= BIT_M1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_dec;
                    end else begin
                        par_bad_q <= (^shift_q) ^ rx_s;
                        state_q   <= STOP;
                        cnt_q     <= BIT_M1;
                    end
                end
`endif
                STOP: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_dec;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= BIT_M1;
                        // A framing error wins over parity and forces a fresh idle period
                        if (!rx_s) begin
                            ferr_q  <= 1'b1;
                            armed_q <= 1'b0;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad_q) begin
                            perr_q <= 1'b1;
                        end
`endif
                        else begin
                            data_q <= shift_q;
                            recv_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_byte_data     = data_q;
    assign o_rx_byte_recv_sig = recv_q;
    assign o_rx_frame_err     = ferr_q;
    assign o_rx_busy          = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_rx_parity_err    = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at CLKS_PER_BIT=8; covers UART_RX_PARITY_EN when defined.
module tb_uart_rx_byte;

    localparam int C    = 8;
    localparam int SYNC = 2;
    localparam int H    = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int KSTOP = 10;
`else
    localparam int KSTOP = 9;
`endif
    localparam int K_RECV = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       recv;
    logic       ferr;
    logic       busy;
    logic       perr;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sbq[$];

    uart_rx_byte #(
        .CLKS_PER_BIT (C),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_uart_rx          (rx),
        .o_rx_byte_data     (data),
        .o_rx_byte_recv_sig (recv),
        .o_rx_frame_err     (ferr),
        .o_rx_busy          (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_rx_parity_err    (perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation
    int   mon_kind;
    int   mon_n;
    exp_t mon_e;
    always @(negedge clk) begin
        mon_n = int'(recv) + int'(ferr) + int'(perr);
        if (mon_n != 0) begin
            checks++;
            if (mon_n > 1) begin
                failures++;
                $display("FAIL pulse_exclusive actual=%0d pulses expected=1", mon_n);
            end
            mon_kind = recv ? K_RECV : (ferr ? K_FERR : K_PERR);
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse kind=%0d data=%02h cyc=%0d expected=no pulse",
                         mon_kind, data, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_kind != mon_e.kind || (mon_kind == K_RECV && data !== mon_e.data)) begin
                    failures++;
                    $display("FAIL pulse_value kind=%0d data=%02h expected kind=%0d data=%02h",
                             mon_kind, data, mon_e.kind, mon_e.data);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL pulse_timing actual_cyc=%0d expected_cyc=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (C) @(negedge clk);
    endtask

    // Called on a negedge; start bit reaches rx_s SYNC+1 edges later (T0)
    task automatic send(input logic [7:0] b, input logic stop_b, input logic pflip, input int kind);
        exp_t e;
        e.kind = kind;
        e.data = b;
        e.cyc  = cyc + SYNC + 1 + H + KSTOP * C;
        sbq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ pflip);
`endif
        drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sbq.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, sbq.size(), 0);
    endtask

    logic saw_busy;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_recv", recv, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        send(8'hA5, 1'b1, 1'b0, K_RECV);
        drain("a5_done");
        check("a5_data", data, 8'hA5);

        send(8'h00, 1'b1, 1'b0, K_RECV);
        send(8'hFF, 1'b1, 1'b0, K_RECV);
        drain("b2b_done");
        check("b2b_data", data, 8'hFF);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy", busy, 1'b0);
        check("glitch_data", data, 8'hFF);
        send(8'h3C, 1'b1, 1'b0, K_RECV);
        drain("3c_done");
        check("3c_data", data, 8'h3C);

        send(8'h5A, 1'b0, 1'b0, K_FERR);
        drain("ferr_done");
        check("ferr_data_hold", data, 8'h3C);
        repeat (8) @(negedge clk);
        send(8'h11, 1'b1, 1'b0, K_RECV);
        drain("11_done");
        check("11_data", data, 8'h11);

        // 0x77 aborted by reset in bit 4, then the line is held low
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_data", data, 8'h00);
        check("midreset_busy", busy, 1'b0);
        rst_n = 1'b1;
        rx = 1'b0;
        saw_busy = 1'b0;
        repeat (44) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rx = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        check("unarmed_no_start", saw_busy, 1'b0);
        check("unarmed_data", data, 8'h00);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        send(8'h42, 1'b1, 1'b0, K_RECV);
        drain("42_done");
        check("42_data", data, 8'h42);

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b1, K_PERR);
        drain("perr_done");
        check("perr_data_hold", data, 8'h42);
        send(8'h03, 1'b1, 1'b0, K_RECV);
        drain("par_ok_done");
        check("par_ok_data", data, 8'h03);
`endif

        repeat (20) @(negedge clk);
        check("final_queue", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
